wave_analyzer: RTL and testbench
================================

Name: wave_analyzer

Overview:
Receive-side counterpart of the DDS waveform generator. Consumes a sample stream, detects period boundaries, and classifies each full period as one of the five generator forms. Reports form code, period length in samples, and per-sample step, which recovers the generator's ADDER. Sits on the capture path (ADC/loopback) for self-test and monitoring of the generator output.

Parameters:
DATA_W, 8, sample width (unsigned)
PERIOD_W, 16, period counter width
MID, 128, mid-level threshold for period markers and high/low duty counting
JUMP_TH, 64, |delta| above this is a wrap/edge jump, not a ramp step
LOCK_N, 2, consecutive identical classifications required for lock

Ports:
CLK  in  1  clock
RESET  in  1  reset, asynchronous, active-high
clear  in  1  synchronous restart to SEEK, same effect as reset except asynchronous behaviour
s_valid  in  1  sample strobe
s_data  in  DATA_W  sample value
form_out  out  3  000 saw, 001 reverse saw, 010 triangle, 011 meander 50%, 100 meander 25%
period_out  out  PERIOD_W  samples per period of last classification
step_out  out  DATA_W  |delta| of last non-zero ramp step, 0 for meanders
result_valid  out  1  one-cycle pulse, outputs updated
locked  out  1  LOCK_N consecutive identical forms with equal period
err  out  1  one-cycle pulse: unclassifiable period or period overflow

Behaviour:
- Reset/clear: all outputs 0, prev sample 0, all accumulators 0, state SEEK.
- Only cycles with s_valid=1 advance anything; delta d = s_data - prev is signed, DATA_W+1 bits; prev <= s_data on every valid sample.
- Delta class: d>JUMP_TH jump_up; d<-JUMP_TH jump_dn; 0<d<=JUMP_TH up; -JUMP_TH<=d<0 down; d=0 flat (ignored).
- Marker: valid sample with prev<MID and s_data>=MID. First valid sample after reset never marks (prev undefined).
- Per-period accumulators, all cleared on marker, with the marker sample counted into the new period: cnt (samples), n_hi (samples >=MID), up flag, dn flag, ju/jd jump counts saturating at 2, step.
- States: SEEK (wait for first marker) -> MEASURE. In MEASURE, each marker closes the period and classifies it:
  up&!dn&jd==1&ju==0 -> 000; dn&!up&ju==1&jd==0 -> 001; up&dn&ju==0&jd==0 -> 010; !up&!dn&ju==1&jd==1 -> 011 if 8*n_hi>=3*cnt, else 100; anything else -> err.
- Latency: result_valid/err asserts on the cycle after the closing marker sample; form_out, period_out, and step_out are updated in the same cycle and held until the next result.
- Lock: match counter increments when form and period equal the previous result and saturates at LOCK_N; locked=1 at LOCK_N. Any mismatch resets the count to 1 and drops locked. err resets the count to 0 and drops locked.
- Overflow: cnt reaching 2^PERIOD_W-1 without a marker -> err pulse, locked=0, state SEEK; outputs keep their last values.
- A marker on the same valid sample as overflow: the marker wins.
- RESET asserted mid-period discards the partial period immediately.

Decomposition:
- Shared package wave_pkg: 3-bit form codes FORM_SAW, FORM_RSAW, FORM_TRI, FORM_MEANDER, FORM_MEANDER25. The generator uses the same constants.
- One sub-module wave_period_acc: delta classification and per-period accumulators, with a clear-on-marker input. The top level holds the SEEK/MEASURE FSM, classifier, and lock logic.

Test Plan:
- Saw 0,4,...,252 repeating -> first result after 2nd marker: form 000, period 64, step 4; locked after 2nd result.
- Reverse saw 252,244,...,4 (step 8) repeating -> form 001, period 32, step 8.
- Triangle 0,2,...,254,252,...,2 repeating -> form 010, period 254, step 2.
- Square 16x255 / 16x0 -> form 011, period 32, step 0. Switch to 8x255 / 24x0 -> one result 100 with locked dropping, then locked again after LOCK_N results.
- Constant 50 for 70000 valid samples after a marker -> err pulse at cnt=65535, locked=0, returns to SEEK. Ramp with an injected +100 glitch -> err on that period.
- RESET pulse mid-period while locked -> outputs 0 immediately; next result only after two fresh markers. s_valid gaps of 3 cycles -> period and form unchanged.

Source files
------------

// File: rtl/wave_pkg.sv
// wave_pkg: form codes and shared types for the DDS
// generator / wave analyzer pair.
package wave_pkg;

   localparam logic [2:0] FORM_SAW       = 3'b000;
   localparam logic [2:0] FORM_RSAW      = 3'b001;
   localparam logic [2:0] FORM_TRI       = 3'b010;
   localparam logic [2:0] FORM_MEANDER   = 3'b011;
   localparam logic [2:0] FORM_MEANDER25 = 3'b100;

   typedef enum logic {
      ST_SEEK,
      ST_MEASURE
   } state_t;

   typedef enum logic [2:0] {
      DC_FLAT,
      DC_UP,
      DC_DN,
      DC_JU,
      DC_JD
   } dclass_t;

   typedef struct packed {
      logic       ok;
      logic [2:0] form;
   } cls_t;

   // Map one closed period's shape flags to a form code.
   function automatic cls_t f_classify(
      input logic       up,
      input logic       dn,
      input logic [1:0] ju,
      input logic [1:0] jd,
      input logic       wide
   );
      cls_t res;
      res = '{ok: 1'b1, form: FORM_SAW};
      unique case (1'b1)
         up && !dn && jd == 2'd1 && ju == 2'd0:
            res.form = FORM_SAW;
         dn && !up && ju == 2'd1 && jd == 2'd0:
            res.form = FORM_RSAW;
         up && dn && ju == 2'd0 && jd == 2'd0:
            res.form = FORM_TRI;
         !up && !dn && ju == 2'd1 && jd == 2'd1:
            res.form = wide ? FORM_MEANDER
                            : FORM_MEANDER25;
         default:
            res.ok = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/wave_analyzer_if.sv
// wave_analyzer_if: sample stream into the analyzer.
// The capture source is master, the analyzer slave.
interface wave_analyzer_if #(
   parameter int DATA_W = 8
);
   logic              s_valid;
   logic [DATA_W-1:0] s_data;

   modport master (
      output s_valid,
      output s_data
   );

   modport slave (
      input s_valid,
      input s_data
   );
endinterface

// File: rtl/wave_period_acc.sv
// wave_period_acc: delta classification, period marker
// and per-period shape accumulators.
module wave_period_acc #(
   parameter int DATA_W   = 8,
   parameter int PERIOD_W = 16,
   parameter int MID      = 128,
   parameter int JUMP_TH  = 64
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                i_clear,
   input  logic                i_valid,
   input  logic [DATA_W-1:0]   i_data,
   input  logic                i_restart,
   output logic                o_marker,
   output logic [PERIOD_W-1:0] o_cnt,
   output logic [PERIOD_W-1:0] o_n_hi,
   output logic                o_up,
   output logic                o_dn,
   output logic [1:0]          o_ju,
   output logic [1:0]          o_jd,
   output logic [DATA_W-1:0]   o_step
);
   import wave_pkg::*;

   localparam logic [DATA_W-1:0] C_MID =
      DATA_W'(MID);
   localparam logic signed [DATA_W:0] C_JTH =
      (DATA_W + 1)'(JUMP_TH);
   localparam logic signed [DATA_W:0] C_NJTH =
      -C_JTH;

   logic [DATA_W-1:0]      r_prev;
   logic                   r_seen;
   logic [PERIOD_W-1:0]    r_cnt;
   logic [PERIOD_W-1:0]    r_n_hi;
   logic                   r_up;
   logic                   r_dn;
   logic [1:0]             r_ju;
   logic [1:0]             r_jd;
   logic [DATA_W-1:0]      r_step;

   logic signed [DATA_W:0] w_d;
   logic [DATA_W-1:0]      w_abs;
   logic                   w_hi;
   logic                   w_ramp;
   dclass_t                w_cls;

   assign w_d = $signed({1'b0, i_data})
              - $signed({1'b0, r_prev});
   assign w_abs = w_d[DATA_W] ? DATA_W'(-w_d)
                              : w_d[DATA_W-1:0];
   assign w_hi = i_data >= C_MID;
   assign w_ramp = (w_cls == DC_UP)
                || (w_cls == DC_DN);

   // A marker needs a real previous sample below MID.
   assign o_marker = i_valid && r_seen
                  && (r_prev < C_MID) && w_hi;

   assign o_cnt  = r_cnt;
   assign o_n_hi = r_n_hi;
   assign o_up   = r_up;
   assign o_dn   = r_dn;
   assign o_ju   = r_ju;
   assign o_jd   = r_jd;
   assign o_step = r_step;

   // Bucket the signed delta; zero delta stays flat.
   always_comb begin
      w_cls = DC_FLAT;
      unique case (1'b1)
         w_d > C_JTH:
            w_cls = DC_JU;
         w_d < C_NJTH:
            w_cls = DC_JD;
         !w_d[DATA_W] && w_d != '0
            && w_d <= C_JTH:
            w_cls = DC_UP;
         w_d[DATA_W] && w_d >= C_NJTH:
            w_cls = DC_DN;
         default:
            w_cls = DC_FLAT;
      endcase
   end

   // Accumulate; a restart opens a period holding
   // the marker sample itself, delta included.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_prev <= '0;
         r_seen <= 1'b0;
         r_cnt  <= '0;
         r_n_hi <= '0;
         r_up   <= 1'b0;
         r_dn   <= 1'b0;
         r_ju   <= '0;
         r_jd   <= '0;
         r_step <= '0;
      end else if (i_clear) begin
         r_prev <= '0;
         r_seen <= 1'b0;
         r_cnt  <= '0;
         r_n_hi <= '0;
         r_up   <= 1'b0;
         r_dn   <= 1'b0;
         r_ju   <= '0;
         r_jd   <= '0;
         r_step <= '0;
      end else if (i_valid) begin
         r_prev <= i_data;
         r_seen <= 1'b1;
         if (i_restart) begin
            r_cnt  <= PERIOD_W'(1);
            r_n_hi <= PERIOD_W'(w_hi);
            r_up   <= w_cls == DC_UP;
            r_dn   <= w_cls == DC_DN;
            r_ju   <= (w_cls == DC_JU) ? 2'd1 : 2'd0;
            r_jd   <= (w_cls == DC_JD) ? 2'd1 : 2'd0;
            r_step <= w_ramp ? w_abs : '0;
         end else begin
            if (r_cnt != '1)
               r_cnt <= r_cnt + 1'b1;
            if (w_hi && r_n_hi != '1)
               r_n_hi <= r_n_hi + 1'b1;
            if (w_cls == DC_UP)
               r_up <= 1'b1;
            if (w_cls == DC_DN)
               r_dn <= 1'b1;
            if (w_cls == DC_JU && r_ju != 2'd2)
               r_ju <= r_ju + 2'd1;
            if (w_cls == DC_JD && r_jd != 2'd2)
               r_jd <= r_jd + 2'd1;
            if (w_ramp)
               r_step <= w_abs;
         end
      end
   end

endmodule

// File: rtl/wave_analyzer.sv
// wave_analyzer: classifies each full period of a
// captured DDS waveform and tracks lock on it.
module wave_analyzer #(
   parameter int DATA_W   = 8,
   parameter int PERIOD_W = 16,
   parameter int MID      = 128,
   parameter int JUMP_TH  = 64,
   parameter int LOCK_N   = 2
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                clear,
   wave_analyzer_if.slave      s_if,
   output logic [2:0]          form_out,
   output logic [PERIOD_W-1:0] period_out,
   output logic [DATA_W-1:0]   step_out,
   output logic                result_valid,
   output logic                locked,
   output logic                err
);
   import wave_pkg::*;

   localparam int MW = $clog2(LOCK_N + 1);
   localparam logic [MW-1:0] C_LOCK = MW'(LOCK_N);
   localparam logic [PERIOD_W-1:0] C_OVF =
      {{(PERIOD_W - 1){1'b1}}, 1'b0};

   logic                w_marker;
   logic [PERIOD_W-1:0] w_cnt;
   logic [PERIOD_W-1:0] w_n_hi;
   logic                w_up;
   logic                w_dn;
   logic [1:0]          w_ju;
   logic [1:0]          w_jd;
   logic [DATA_W-1:0]   w_step;

   logic [PERIOD_W+2:0] w_hi8;
   logic [PERIOD_W+2:0] w_cnt3;
   logic                w_wide;
   cls_t                w_cls;
   logic                w_ovf;
   logic                w_same;
   logic                w_res;
   logic                w_err;
   logic [MW-1:0]       w_match_nx;

   state_t              r_state;
   state_t              w_state_nx;
   logic [2:0]          r_form;
   logic [PERIOD_W-1:0] r_period;
   logic [DATA_W-1:0]   r_step;
   logic                r_valid;
   logic                r_locked;
   logic                r_err;
   logic [MW-1:0]       r_match;

   wave_period_acc #(
      .DATA_W   (DATA_W),
      .PERIOD_W (PERIOD_W),
      .MID      (MID),
      .JUMP_TH  (JUMP_TH)
   ) u_acc (
      .CLK       (CLK),
      .RESET     (RESET),
      .i_clear   (clear),
      .i_valid   (s_if.s_valid),
      .i_data    (s_if.s_data),
      .i_restart (w_marker),
      .o_marker  (w_marker),
      .o_cnt     (w_cnt),
      .o_n_hi    (w_n_hi),
      .o_up      (w_up),
      .o_dn      (w_dn),
      .o_ju      (w_ju),
      .o_jd      (w_jd),
      .o_step    (w_step)
   );

   // 8*n_hi >= 3*cnt splits 50% from 25% meander.
   assign w_hi8  = {w_n_hi, 3'b000};
   assign w_cnt3 = {2'b00, w_cnt, 1'b0}
                 + {3'b000, w_cnt};
   assign w_wide = w_hi8 >= w_cnt3;
   assign w_cls  = f_classify(w_up, w_dn, w_ju,
                              w_jd, w_wide);

   // A marker on the overflow sample takes priority.
   assign w_ovf  = s_if.s_valid && !w_marker
                && (w_cnt == C_OVF);
   assign w_same = (w_cls.form == r_form)
                && (w_cnt == r_period);

   assign form_out     = r_form;
   assign period_out   = r_period;
   assign step_out     = r_step;
   assign result_valid = r_valid;
   assign locked       = r_locked;
   assign err          = r_err;

   // SEEK/MEASURE next state and result/error strobes.
   always_comb begin
      w_state_nx = r_state;
      w_res      = 1'b0;
      w_err      = 1'b0;
      unique case (r_state)
         ST_SEEK: begin
            if (w_marker)
               w_state_nx = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (w_marker) begin
               w_res = w_cls.ok;
               w_err = !w_cls.ok;
            end else if (w_ovf) begin
               w_err      = 1'b1;
               w_state_nx = ST_SEEK;
            end
         end
      endcase
   end

   // Lock run length: repeats count up, errors zero it.
   always_comb begin
      w_match_nx = r_match;
      if (w_err) begin
         w_match_nx = '0;
      end else if (w_res) begin
         if (!w_same)
            w_match_nx = MW'(1);
         else if (r_match != C_LOCK)
            w_match_nx = r_match + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         r_state <= ST_SEEK;
      else if (clear)
         r_state <= ST_SEEK;
      else
         r_state <= w_state_nx;
   end

   // Result registers; held until the next good result.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_form   <= '0;
         r_period <= '0;
         r_step   <= '0;
         r_valid  <= 1'b0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
         r_match  <= '0;
      end else if (clear) begin
         r_form   <= '0;
         r_period <= '0;
         r_step   <= '0;
         r_valid  <= 1'b0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
         r_match  <= '0;
      end else begin
         r_valid  <= w_res;
         r_err    <= w_err;
         r_match  <= w_match_nx;
         r_locked <= w_match_nx == C_LOCK;
         if (w_res) begin
            r_form   <= w_cls.form;
            r_period <= w_cnt;
            r_step   <= w_step;
         end
      end
   end

endmodule

// File: tb/tb_wave_analyzer.sv
// tb_wave_analyzer: directed waveform vectors with
// hand-computed form, period, step and lock results.
module tb_wave_analyzer;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        clear;
   logic [2:0]  form_out;
   logic [15:0] period_out;
   logic [7:0]  step_out;
   logic        result_valid;
   logic        locked;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;
   int n_res  = 0;
   int n_err  = 0;
   int b_res;
   int b_err;

   wave_analyzer_if #(.DATA_W(8)) u_if ();

   wave_analyzer dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .clear        (clear),
      .s_if         (u_if),
      .form_out     (form_out),
      .period_out   (period_out),
      .step_out     (step_out),
      .result_valid (result_valid),
      .locked       (locked),
      .err          (err)
   );

   always #5 CLK = ~CLK;

   // Count result and error pulses away from the edge.
   always @(negedge CLK) begin
      if (result_valid)
         n_res <= n_res + 1;
      if (err)
         n_err <= n_err + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] v,
                       input int gap = 0);
      @(negedge CLK);
      u_if.s_valid = 1'b1;
      u_if.s_data  = v;
      @(posedge CLK);
      #1;
      u_if.s_valid = 1'b0;
      repeat (gap) @(posedge CLK);
   endtask

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic do_clear();
      @(negedge CLK);
      clear = 1'b1;
      @(posedge CLK);
      #1;
      clear = 1'b0;
   endtask

   task automatic saw_loop(input int gap = 0,
                           input int glitch = -1);
      for (int i = 0; i < 64; i++)
         send(8'((i == glitch) ? i * 4 + 100 : i * 4),
              gap);
   endtask

   task automatic rsaw_loop();
      for (int i = 0; i < 32; i++)
         send(8'(252 - 8 * i));
   endtask

   task automatic tri_loop();
      for (int i = 0; i < 128; i++)
         send(8'(2 * i));
      for (int i = 126; i > 0; i--)
         send(8'(2 * i));
   endtask

   task automatic sq_loop(input int hi);
      for (int i = 0; i < 32; i++)
         send((i < hi) ? 8'd255 : 8'd0);
   endtask

   initial begin
      RESET        = 1'b1;
      clear        = 1'b0;
      u_if.s_valid = 1'b0;
      u_if.s_data  = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_form", 32'(form_out), 0);
      chk("rst_period", 32'(period_out), 0);
      chk("rst_step", 32'(step_out), 0);
      chk("rst_valid", 32'(result_valid), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_err", 32'(err), 0);
      @(negedge CLK);
      RESET = 1'b0;

      // saw, step 4
      b_res = n_res;
      saw_loop();
      saw_loop();
      tick();
      chk("saw_res1", 32'(n_res - b_res), 1);
      chk("saw_lock1", 32'(locked), 0);
      chk("saw_form", 32'(form_out), 0);
      chk("saw_period", 32'(period_out), 64);
      chk("saw_step", 32'(step_out), 4);
      saw_loop();
      tick();
      chk("saw_res2", 32'(n_res - b_res), 2);
      chk("saw_lock2", 32'(locked), 1);

      do_clear();
      chk("clr_period", 32'(period_out), 0);
      chk("clr_step", 32'(step_out), 0);
      chk("clr_locked", 32'(locked), 0);

      // reverse saw, step 8
      b_res = n_res;
      repeat (4) rsaw_loop();
      tick();
      chk("rsaw_res", 32'(n_res - b_res), 2);
      chk("rsaw_form", 32'(form_out), 1);
      chk("rsaw_period", 32'(period_out), 32);
      chk("rsaw_step", 32'(step_out), 8);
      chk("rsaw_lock", 32'(locked), 1);

      // triangle, step 2
      do_clear();
      b_res = n_res;
      repeat (3) tri_loop();
      tick();
      chk("tri_res", 32'(n_res - b_res), 2);
      chk("tri_form", 32'(form_out), 2);
      chk("tri_period", 32'(period_out), 254);
      chk("tri_step", 32'(step_out), 2);
      chk("tri_lock", 32'(locked), 1);

      // meander 50% then 25%
      do_clear();
      b_res = n_res;
      repeat (4) sq_loop(16);
      tick();
      chk("sq_res", 32'(n_res - b_res), 2);
      chk("sq_form", 32'(form_out), 3);
      chk("sq_period", 32'(period_out), 32);
      chk("sq_step", 32'(step_out), 0);
      chk("sq_lock", 32'(locked), 1);
      sq_loop(8);
      sq_loop(8);
      tick();
      chk("m25_res", 32'(n_res - b_res), 4);
      chk("m25_form", 32'(form_out), 4);
      chk("m25_period", 32'(period_out), 32);
      chk("m25_unlock", 32'(locked), 0);
      sq_loop(8);
      tick();
      chk("m25_res2", 32'(n_res - b_res), 5);
      chk("m25_relock", 32'(locked), 1);

      // overflow: marker then flat samples
      b_err = n_err;
      send(8'd200);
      tick();
      chk("ovf_res", 32'(n_res - b_res), 6);
      repeat (65533) send(8'd50);
      chk("ovf_early", 32'(err), 0);
      send(8'd50);
      chk("ovf_err", 32'(err), 1);
      chk("ovf_locked", 32'(locked), 0);
      chk("ovf_valid", 32'(result_valid), 0);
      chk("ovf_form", 32'(form_out), 4);
      chk("ovf_period", 32'(period_out), 32);
      @(posedge CLK);
      #1;
      chk("ovf_pulse", 32'(err), 0);
      chk("ovf_nerr", 32'(n_err - b_err), 1);
      send(8'd200);
      tick();
      chk("ovf_seek", 32'(n_res - b_res), 6);

      // saw with a +100 glitch in one period
      do_clear();
      b_res = n_res;
      b_err = n_err;
      saw_loop();
      saw_loop();
      tick();
      chk("gl_res1", 32'(n_res - b_res), 1);
      saw_loop(0, 5);
      tick();
      chk("gl_err", 32'(n_err - b_err), 1);
      chk("gl_res_hold", 32'(n_res - b_res), 1);
      chk("gl_locked", 32'(locked), 0);
      saw_loop();
      tick();
      chk("gl_res2", 32'(n_res - b_res), 2);
      chk("gl_lock2", 32'(locked), 0);
      saw_loop();
      tick();
      chk("gl_res3", 32'(n_res - b_res), 3);
      chk("gl_lock3", 32'(locked), 1);

      // async reset mid-period while locked
      for (int i = 0; i <= 50; i++)
         send(8'(i * 4));
      #2;
      RESET = 1'b1;
      #1;
      chk("ar_period", 32'(period_out), 0);
      chk("ar_step", 32'(step_out), 0);
      chk("ar_locked", 32'(locked), 0);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      b_res = n_res;
      for (int i = 51; i < 64; i++)
         send(8'(i * 4));
      saw_loop();
      tick();
      chk("ar_nores", 32'(n_res - b_res), 0);
      saw_loop();
      tick();
      chk("ar_res1", 32'(n_res - b_res), 1);
      chk("ar_period1", 32'(period_out), 64);
      chk("ar_lock1", 32'(locked), 0);

      // 3-cycle valid gaps leave the result unchanged
      saw_loop(3);
      saw_loop(3);
      tick();
      chk("gap_res", 32'(n_res - b_res), 3);
      chk("gap_form", 32'(form_out), 0);
      chk("gap_period", 32'(period_out), 64);
      chk("gap_step", 32'(step_out), 4);
      chk("gap_lock", 32'(locked), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
